spwm_dt_modulator: RTL

//  Three-phase sine-triangle PWM stage, directly downstream of the sine LUT generator.
//  - Consumes its three signed 12-bit references: Out1/Out2/Out3 to ref_a/ref_b/ref_c.
//  - Compares each reference against a shared triangular carrier.
//  - Drives complementary high/low gate pairs with programmable dead time.
//  - Provides a latched fault shutdown.

---
 rtl/spwm_dt_modulator.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/spwm_dt_modulator.sv
// -----------------------------------------------------------------------------
// spwm_dt_modulator
// Three-phase sine-triangle PWM stage with complementary gate pairs,
// programmable dead time and a latched fault shutdown.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active high
//   en         carrier step strobe (one clk wide)
//   ref_a/b/c  signed phase references, latched at each carrier reversal
//   fault      external trip, level sensitive
//   fault_clr  clears the latched fault (ignored while fault=1)
//   gate_hi    registered high-side drives {C,B,A}
//   gate_lo    registered low-side drives {C,B,A}
//   carrier    current triangular carrier value, signed
//   sync_pk    one-clk pulse on the edge where the carrier reverses
//   fault_lat  latched fault status
// -----------------------------------------------------------------------------
module spwm_dt_modulator #(
    parameter int W       = 12,
    parameter int CNT_MAX = 2047,
    parameter int DEAD    = 8,
    parameter int DT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] ref_a,
    input  logic signed [W-1:0] ref_b,
    input  logic signed [W-1:0] ref_c,
    input  logic                fault,
    input  logic                fault_clr,
    output logic [2:0]          gate_hi,
    output logic [2:0]          gate_lo,
    output logic signed [W-1:0] carrier,
    output logic                sync_pk,
    output logic                fault_lat
);

    typedef enum logic [1:0] {
        LO_ON = 2'd0,
        DT_HI = 2'd1,
        HI_ON = 2'd2,
        DT_LO = 2'd3
    } phase_state_e;

    localparam logic signed [W-1:0] CAR_TOP = W'(CNT_MAX);
    localparam logic signed [W-1:0] CAR_BOT = W'(-CNT_MAX);
    localparam logic signed [W-1:0] CAR_ONE = W'(1);
    localparam logic [DT_W-1:0]     DT_LOAD = DT_W'(DEAD);
    localparam logic [DT_W-1:0]     DT_ONE  = DT_W'(1);

    logic signed [W-1:0] carrier_q;
    logic signed [W-1:0] carrier_d;
    logic                dir_up_q;
    logic                dir_up_d;
    logic                sync_q;
    logic                sync_d;
    logic signed [W-1:0] ref_in_s  [3];
    logic signed [W-1:0] ref_lat_q [3];
    logic signed [W-1:0] ref_lat_d [3];
    logic                fault_lat_q;
    logic                fault_lat_d;
    logic [2:0]          dem_s;
    phase_state_e        state_q   [3];
    phase_state_e        state_d   [3];
    logic [DT_W-1:0]     dt_cnt_q  [3];
    logic [DT_W-1:0]     dt_cnt_d  [3];
    logic [2:0]          gate_hi_d;
    logic [2:0]          gate_lo_d;
    logic [2:0]          gate_hi_q;
    logic [2:0]          gate_lo_q;

    assign ref_in_s[0] = ref_a;
    assign ref_in_s[1] = ref_b;
    assign ref_in_s[2] = ref_c;

    // Carrier up/down stepping, reversal pulse and double-update reference latch
    always_comb begin
        carrier_d = carrier_q;
        dir_up_d  = dir_up_q;
        sync_d    = 1'b0;
        if (en) begin
            if (dir_up_q) begin
                if (carrier_q == CAR_TOP) begin
                    carrier_d = CAR_TOP - CAR_ONE;
                    dir_up_d  = 1'b0;
                    sync_d    = 1'b1;
                end else begin
                    carrier_d = carrier_q + CAR_ONE;
                end
            end else begin
                if (carrier_q == CAR_BOT) begin
                    carrier_d = CAR_BOT + CAR_ONE;
                    dir_up_d  = 1'b1;
                    sync_d    = 1'b1;
                end else begin
                    carrier_d = carrier_q - CAR_ONE;
                end
            end
        end else begin
            carrier_d = carrier_q;
        end
        // References only change at a reversal so mid-update skew never reaches the compare
        for (int p = 0; p < 3; p++) begin
            if (sync_d) begin
                ref_lat_d[p] = ref_in_s[p];
            end else begin
                ref_lat_d[p] = ref_lat_q[p];
            end
        end
    end

    // Fault latch: a live trip always beats a clear request
    always_comb begin
        if (fault) begin
            fault_lat_d = 1'b1;
        end else if (fault_clr) begin
            fault_lat_d = 1'b0;
        end else begin
            fault_lat_d = fault_lat_q;
        end
    end

    // Demand per phase: strictly greater, equality keeps the low side on
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            dem_s[p] = (ref_lat_q[p] > carrier_q);
        end
    end

    // Per-phase next state; the dead-time counter is never reloaded mid-countdown
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            state_d[p]  = state_q[p];
            dt_cnt_d[p] = dt_cnt_q[p];
            // The clear edge itself still holds, so the full countdown follows it
            if (fault || fault_lat_q) begin
                state_d[p]  = DT_LO;
                dt_cnt_d[p] = DT_LOAD;
            end else begin
                case (state_q[p])
                    LO_ON: begin
                        if (dem_s[p]) begin
                            state_d[p]  = DT_HI;
                            dt_cnt_d[p] = DT_LOAD;
                        end else begin
                            state_d[p]  = LO_ON;
                        end
                    end
                    HI_ON: begin
                        if (!dem_s[p]) begin
                            state_d[p]  = DT_LO;
                            dt_cnt_d[p] = DT_LOAD;
                        end else begin
                            state_d[p]  = HI_ON;
                        end
                    end
                    DT_HI, DT_LO: begin
                        dt_cnt_d[p] = dt_cnt_q[p] - DT_ONE;
                        // '<=' rather than '==' so a corrupted zero count still expires
                        if (dt_cnt_q[p] <= DT_ONE) begin
                            if (dem_s[p]) begin
                                state_d[p] = HI_ON;
                            end else begin
                                state_d[p] = LO_ON;
                            end
                        end else begin
                            state_d[p] = state_q[p];
                        end
                    end
                    default: begin
                        state_d[p]  = DT_LO;
                        dt_cnt_d[p] = DT_LOAD;
                    end
                endcase
            end
        end
    end

    // Gate decode from the next state: hi and lo are exclusive by construction
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            gate_hi_d[p] = (state_d[p] == HI_ON);
            gate_lo_d[p] = (state_d[p] == LO_ON);
        end
    end

    // All state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carrier_q   <= CAR_BOT;
            dir_up_q    <= 1'b1;
            sync_q      <= 1'b0;
            fault_lat_q <= 1'b0;
            gate_hi_q   <= 3'b000;
            gate_lo_q   <= 3'b000;
            for (int p = 0; p < 3; p++) begin
                ref_lat_q[p] <= '0;
                state_q[p]   <= DT_LO;
                dt_cnt_q[p]  <= DT_LOAD;
            end
        end else begin
            carrier_q   <= carrier_d;
            dir_up_q    <= dir_up_d;
            sync_q      <= sync_d;
            fault_lat_q <= fault_lat_d;
            gate_hi_q   <= gate_hi_d;
            gate_lo_q   <= gate_lo_d;
            for (int p = 0; p < 3; p++) begin
                ref_lat_q[p] <= ref_lat_d[p];
                state_q[p]   <= state_d[p];
                dt_cnt_q[p]  <= dt_cnt_d[p];
            end
        end
    end

    assign gate_hi   = gate_hi_q;
    assign gate_lo   = gate_lo_q;
    assign carrier   = carrier_q;
    assign sync_pk   = sync_q;
    assign fault_lat = fault_lat_q;

endmodule
